// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Generates 640x480 @ 60 Hz VGA raster timing from a single master clock.
// A pixel-rate clock enable is produced by dividing the master clock by
// CLK_DIV. At each advance edge the raster coordinates step, and the
// horizontal and vertical phase state machines decide the sync and blanking
// outputs. Every output is registered and updated at the same advance edge,
// so coordinates, enable and syncs are always mutually consistent.
//
// Ports:
//   Master_Clock_In  in   1   master clock (only clock in the block)
//   Reset_N_In       in   1   asynchronous active-low reset
//   Val_Row_Out      out  10  horizontal position, 0..H_TOTAL-1
//   Val_Col_Out      out  10  vertical position, 0..V_TOTAL-1
//   Disp_Ena_Out     out  1   high inside the visible area
//   H_Sync_Out       out  1   horizontal sync
//   V_Sync_Out       out  1   vertical sync
//   Pixel_Tick_Out   out  1   one-cycle pulse when new coordinates appear
//   Frame_Start_Out  out  1   one-cycle pulse when (0,0) is presented
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    output logic [9:0] Val_Row_Out,
    output logic [9:0] Val_Col_Out,
    output logic       Disp_Ena_Out,
    output logic       H_Sync_Out,
    output logic       V_Sync_Out,
    output logic       Pixel_Tick_Out,
    output logic       Frame_Start_Out
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // A divide-by-one still needs a 1-bit counter that simply stays at zero.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // Same classification serves both axes; only the boundaries differ.
    function automatic phase_t phase_of(
        input logic [9:0] pos,
        input logic [9:0] front_start,
        input logic [9:0] sync_start,
        input logic [9:0] back_start
    );
        if (pos < front_start)     return PH_ACTIVE;
        else if (pos < sync_start) return PH_FRONT;
        else if (pos < back_start) return PH_SYNC;
        else                       return PH_BACK;
    endfunction

    logic [DIV_W-1:0] divider;
    logic             advance;
    logic             line_wrap;
    logic [9:0]       row_next;
    logic [9:0]       col_next;
    phase_t           h_state, h_state_next;
    phase_t           v_state, v_state_next;

    assign advance = (divider == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of process order.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            divider <= '0;
        end else if (advance) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Next coordinates and next phases. Phases are decoded from the next
    // coordinate so state and coordinates change on the same edge.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this combinational block from inferring latches.
    always_comb begin
        row_next     = Val_Row_Out;
        col_next     = Val_Col_Out;
        line_wrap    = 1'b0;
        h_state_next = h_state;
        v_state_next = v_state;
        if (advance) begin
            if (Val_Row_Out == H_LAST) begin
                row_next  = '0;
                line_wrap = 1'b1;
            end else begin
                row_next = Val_Row_Out + 10'd1;
            end
            h_state_next = phase_of(row_next, H_FRONT_START, H_SYNC_START, H_BACK_START);

            // The vertical machine only moves on a line wrap.
            if (line_wrap) begin
                col_next     = (Val_Col_Out == V_LAST) ? 10'd0 : Val_Col_Out + 10'd1;
                v_state_next = phase_of(col_next, V_FRONT_START, V_SYNC_START, V_BACK_START);
            end
        end
    end

    // State and output registers. Outside advance edges the next values equal
    // the current ones, so all outputs hold steady between pixels.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            h_state         <= PH_BACK;
            v_state         <= PH_BACK;
            Val_Row_Out     <= H_LAST;
            Val_Col_Out     <= V_LAST;
            Disp_Ena_Out    <= 1'b0;
            H_Sync_Out      <= SYNC_OFF;
            V_Sync_Out      <= SYNC_OFF;
            Pixel_Tick_Out  <= 1'b0;
            Frame_Start_Out <= 1'b0;
        end else begin
            h_state         <= h_state_next;
            v_state         <= v_state_next;
            Val_Row_Out     <= row_next;
            Val_Col_Out     <= col_next;
            Disp_Ena_Out    <= (h_state_next == PH_ACTIVE) && (v_state_next == PH_ACTIVE);
            H_Sync_Out      <= (h_state_next == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            V_Sync_Out      <= (v_state_next == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            Pixel_Tick_Out  <= advance;
            Frame_Start_Out <= advance && (row_next == 10'd0) && (col_next == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Three instances share one clock:
//   a : default 640x480 timing, CLK_DIV = 4 (reset, first pixel, line timing)
//   b : scaled-down raster, CLK_DIV = 2 (whole frames, mid-frame reset)
//       H: 8 active, 2 front, 3 sync, 2 back -> 15 ; V: 6, 2, 2, 3 -> 13
//   c : default timing, CLK_DIV = 1 (tick every cycle, line length)
// Inputs change on the falling edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic [9:0] a_row, a_col, b_row, b_col, c_row, c_col;
    logic a_de, a_hs, a_vs, a_tick, a_fs;
    logic b_de, b_hs, b_vs, b_tick, b_fs;
    logic c_de, c_hs, c_vs, c_tick, c_fs;

    int n_pass  = 0;
    int n_total = 0;

    vga_timing_gen u_a (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_a),
        .Val_Row_Out     (a_row),
        .Val_Col_Out     (a_col),
        .Disp_Ena_Out    (a_de),
        .H_Sync_Out      (a_hs),
        .V_Sync_Out      (a_vs),
        .Pixel_Tick_Out  (a_tick),
        .Frame_Start_Out (a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV (2),
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_b (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_b),
        .Val_Row_Out     (b_row),
        .Val_Col_Out     (b_col),
        .Disp_Ena_Out    (b_de),
        .H_Sync_Out      (b_hs),
        .V_Sync_Out      (b_vs),
        .Pixel_Tick_Out  (b_tick),
        .Frame_Start_Out (b_fs)
    );

    vga_timing_gen #(
        .CLK_DIV (1)
    ) u_c (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_c),
        .Val_Row_Out     (c_row),
        .Val_Col_Out     (c_col),
        .Disp_Ena_Out    (c_de),
        .H_Sync_Out      (c_hs),
        .V_Sync_Out      (c_vs),
        .Pixel_Tick_Out  (c_tick),
        .Frame_Start_Out (c_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    initial begin
        int cycles, ticks, fe, vs_low, bad, prev_row, prev_col, hs_low;

        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset values (instance a) ----------------
        check("a_rst_row",   32'(a_row),  32'd799);
        check("a_rst_col",   32'(a_col),  32'd524);
        check("a_rst_de",    32'(a_de),   32'd0);
        check("a_rst_hs",    32'(a_hs),   32'd1);
        check("a_rst_vs",    32'(a_vs),   32'd1);
        check("a_rst_tick",  32'(a_tick), 32'd0);
        check("a_rst_fs",    32'(a_fs),   32'd0);

        // ---------------- release: (0,0) at the 4th edge ----------------
        rst_a = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check("a_pre_tick", 32'(a_tick), 32'd0);
        end
        check("a_pre_row", 32'(a_row), 32'd799);
        @(negedge clk);
        check("a_first_row",  32'(a_row),  32'd0);
        check("a_first_col",  32'(a_col),  32'd0);
        check("a_first_de",   32'(a_de),   32'd1);
        check("a_first_tick", 32'(a_tick), 32'd1);
        check("a_first_fs",   32'(a_fs),   32'd1);
        @(negedge clk);
        check("a_tick_pulse", 32'(a_tick), 32'd0);
        check("a_fs_pulse",   32'(a_fs),   32'd0);
        check("a_row_hold",   32'(a_row),  32'd0);
        repeat (3) @(negedge clk);
        check("a_second_row",  32'(a_row),  32'd1);
        check("a_second_tick", 32'(a_tick), 32'd1);
        check("a_second_fs",   32'(a_fs),   32'd0);

        // ---------------- horizontal window ----------------
        for (int i = 0; i < 4000 && a_row !== 10'd639; i++) @(negedge clk);
        check("a_row639", 32'(a_row), 32'd639);
        check("a_de639",  32'(a_de),  32'd1);
        for (int i = 0; i < 8 && a_row !== 10'd640; i++) @(negedge clk);
        check("a_row640", 32'(a_row), 32'd640);
        check("a_de640",  32'(a_de),  32'd0);
        check("a_hs640",  32'(a_hs),  32'd1);
        for (int i = 0; i < 4000 && a_row !== 10'd655; i++) @(negedge clk);
        check("a_hs655", 32'(a_hs), 32'd1);
        for (int i = 0; i < 8 && a_row !== 10'd656; i++) @(negedge clk);
        check("a_row656", 32'(a_row), 32'd656);
        check("a_hs656",  32'(a_hs),  32'd0);
        for (int i = 0; i < 4000 && a_row !== 10'd751; i++) @(negedge clk);
        check("a_hs751", 32'(a_hs), 32'd0);
        for (int i = 0; i < 8 && a_row !== 10'd752; i++) @(negedge clk);
        check("a_row752", 32'(a_row), 32'd752);
        check("a_hs752",  32'(a_hs),  32'd1);

        // ---------------- line wrap (799,0) -> (0,1) ----------------
        for (int i = 0; i < 4000 && a_row !== 10'd799; i++) @(negedge clk);
        check("a_col799", 32'(a_col), 32'd0);
        check("a_de799",  32'(a_de),  32'd0);
        for (int i = 0; i < 8 && a_row !== 10'd0; i++) @(negedge clk);
        check("a_wrap_row", 32'(a_row), 32'd0);
        check("a_wrap_col", 32'(a_col), 32'd1);
        check("a_wrap_de",  32'(a_de),  32'd1);
        check("a_wrap_vs",  32'(a_vs),  32'd1);
        check("a_wrap_fs",  32'(a_fs),  32'd0);

        // ---------------- small raster: full frame ----------------
        rst_b = 1'b1;
        @(negedge clk);
        check("b_pre_tick", 32'(b_tick), 32'd0);
        check("b_pre_row",  32'(b_row),  32'd14);
        @(negedge clk);
        check("b_first_row", 32'(b_row), 32'd0);
        check("b_first_col", 32'(b_col), 32'd0);
        check("b_first_fs",  32'(b_fs),  32'd1);

        cycles = 0; ticks = 0; fe = 0; vs_low = 0; bad = 0; prev_row = 0; prev_col = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cycles++;
            if (b_tick) begin
                ticks++;
                if (b_fs) break;
                if (b_row == 10'd8 && b_col == 10'd6) fe++;
                if (!b_vs) vs_low++;
                if (b_de !== (b_row < 10'd8 && b_col < 10'd6)) bad++;
                if (b_hs !== !(b_row >= 10'd10 && b_row <= 10'd12)) bad++;
                if (b_vs !== !(b_col >= 10'd8 && b_col <= 10'd9)) bad++;
                prev_row = int'(b_row);
                prev_col = int'(b_col);
            end
        end
        check("b_frame_fs",     32'(b_fs),     32'd1);
        check("b_frame_row",    32'(b_row),    32'd0);
        check("b_frame_col",    32'(b_col),    32'd0);
        check("b_frame_ticks",  32'(ticks),    32'd195);
        check("b_frame_cycles", 32'(cycles),   32'd390);
        check("b_frame_end",    32'(fe),       32'd1);
        check("b_vs_ticks",     32'(vs_low),   32'd30);
        check("b_model_bad",    32'(bad),      32'd0);
        check("b_last_row",     32'(prev_row), 32'd14);
        check("b_last_col",     32'(prev_col), 32'd12);

        // ---------------- small raster: async reset mid-frame ----------------
        for (int i = 0; i < 1000 && !(b_row == 10'd5 && b_col == 10'd3); i++) @(negedge clk);
        check("b_mid_row", 32'(b_row), 32'd5);
        check("b_mid_col", 32'(b_col), 32'd3);
        #2 rst_b = 1'b0;
        #1;
        check("b_async_row",  32'(b_row),  32'd14);
        check("b_async_col",  32'(b_col),  32'd12);
        check("b_async_de",   32'(b_de),   32'd0);
        check("b_async_hs",   32'(b_hs),   32'd1);
        check("b_async_vs",   32'(b_vs),   32'd1);
        check("b_async_tick", 32'(b_tick), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_re_pre_tick", 32'(b_tick), 32'd0);
        check("b_re_pre_row",  32'(b_row),  32'd14);
        @(negedge clk);
        check("b_re_row",  32'(b_row),  32'd0);
        check("b_re_col",  32'(b_col),  32'd0);
        check("b_re_de",   32'(b_de),   32'd1);
        check("b_re_tick", 32'(b_tick), 32'd1);
        check("b_re_fs",   32'(b_fs),   32'd1);

        // ---------------- CLK_DIV = 1 ----------------
        check("c_rst_row", 32'(c_row), 32'd799);
        rst_c = 1'b1;
        @(negedge clk);
        check("c_first_row",  32'(c_row),  32'd0);
        check("c_first_tick", 32'(c_tick), 32'd1);
        check("c_first_fs",   32'(c_fs),   32'd1);
        ticks = 0; hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (c_tick) ticks++;
            if (!c_hs) hs_low++;
        end
        check("c_line_ticks", 32'(ticks),  32'd800);
        check("c_hs_low",     32'(hs_low), 32'd96);
        check("c_line_row",   32'(c_row),  32'd0);
        check("c_line_col",   32'(c_col),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
